// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//
// Contents:
//   F3_B, F3_H, F3_W, F3_BU, F3_HU : func3 access size/sign encodings
//   MMIO_ADDR                      : byte address of the word-wide MMIO register
//
// Optional feature macro used by the importing RTL: DMEM_MMIO_EN.
package Pipe_Buf_Reg_PKG;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned MMIO_ADDR = 32'h0000_01FC;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational lane formatter for a 32-bit little-endian data memory.
//
// Ports:
//   func3    in   access size/sign (B, H, W, BU, HU)
//   addr_lo  in   byte lane within the word (addr[1:0])
//   word_in  in   current contents of the addressed storage word
//   wr_data  in   right-aligned store data
//   ld_data  out  extracted and sign/zero-extended load value
//   st_word  out  word_in with the store's byte lanes replaced by wr_data
//   illegal  out  misaligned access or unsupported func3 encoding
//
// Four byte lanes per word, so DATA_W is expected to be 32.
module dmem_lane_fmt
  import Pipe_Buf_Reg_PKG::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        func3,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] word_in,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] st_word,
  output logic              illegal
);

  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [3:0]        byte_en;
  logic [DATA_W-1:0] wr_rep;

  // Lane extraction: byte at addr_lo, halfword at addr_lo[1].
  assign ld_byte = word_in[{addr_lo, 3'b000} +: 8];
  assign ld_half = word_in[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = '0;
    byte_en = 4'b0000;
    wr_rep  = wr_data;
    illegal = 1'b0;
    case (func3)
      F3_B, F3_BU: begin
        ld_data = (func3 == F3_B) ? {{(DATA_W-8){ld_byte[7]}}, ld_byte}
                                  : {{(DATA_W-8){1'b0}}, ld_byte};
        byte_en = 4'b0001 << addr_lo;
        wr_rep  = {4{wr_data[7:0]}};
      end
      F3_H, F3_HU: begin
        ld_data = (func3 == F3_H) ? {{(DATA_W-16){ld_half[15]}}, ld_half}
                                  : {{(DATA_W-16){1'b0}}, ld_half};
        byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
        wr_rep  = {2{wr_data[15:0]}};
        illegal = addr_lo[0];
      end
      F3_W: begin
        ld_data = word_in;
        byte_en = 4'b1111;
        illegal = (addr_lo != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

  // Replicated store data lets each lane pick from its own position.
  always_comb begin
    st_word = word_in;
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) st_word[8*i +: 8] = wr_rep[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-port data memory responder with zero-cycle loads, edge-committed
// stores, sticky error capture and saturating access counters.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   MemRead, MemWrite  single-cycle load/store requests (both high = store)
//   addr, wr_data      byte address, right-aligned store data
//   func3              access size/sign: B, H, W, BU, HU
//   rd_data            combinational load result (0 unless a legal load)
//   err, err_addr      sticky error flag and address of the first error
//   err_clr            clears err/err_addr (a same-cycle error wins)
//   rd_cnt, wr_cnt     saturating counts of legal loads and stores
//   mmio_data          MMIO register           (DMEM_MMIO_EN only)
//   mmio_valid         one-cycle MMIO strobe   (DMEM_MMIO_EN only)
//
// Handshake: a request is valid for exactly the cycle MemRead/MemWrite is
// high; there is no ready, every request completes in that cycle.
//
// Macro DMEM_MMIO_EN: word 0x1FC becomes a write-strobed register instead of
// storage; non-word accesses to that word are illegal.
module dmem_responder
  import Pipe_Buf_Reg_PKG::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [2:0]            func3,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  err,
  output logic [DM_ADDRESS-1:0] err_addr,
  input  logic                  err_clr,
  output logic [CNT_W-1:0]      rd_cnt,
  output logic [CNT_W-1:0]      wr_cnt
`ifdef DMEM_MMIO_EN
  ,
  output logic [DATA_W-1:0]     mmio_data,
  output logic                  mmio_valid
`endif
);

  localparam int WORDS = 2 ** (DM_ADDRESS - 2);

  logic [DATA_W-1:0]     mem [WORDS];
  logic [DM_ADDRESS-3:0] widx;
  logic [DATA_W-1:0]     cur_word;
  logic [DATA_W-1:0]     ld_data;
  logic [DATA_W-1:0]     st_word;
  logic [DATA_W-1:0]     ld_src;
  logic                  fmt_illegal;
  logic                  mmio_hit;
  logic                  mmio_bad;
  logic                  illegal;
  logic                  legal_ld;
  logic                  legal_st;

  assign widx     = addr[DM_ADDRESS-1:2];
  assign cur_word = mem[widx];

  dmem_lane_fmt #(.DATA_W(DATA_W)) u_fmt (
    .func3   (func3),
    .addr_lo (addr[1:0]),
    .word_in (cur_word),
    .wr_data (wr_data),
    .ld_data (ld_data),
    .st_word (st_word),
    .illegal (fmt_illegal)
  );

`ifdef DMEM_MMIO_EN
  localparam logic [DM_ADDRESS-1:0] MMIO_A = DM_ADDRESS'(MMIO_ADDR);
  assign mmio_hit = (widx == MMIO_A[DM_ADDRESS-1:2]);
  assign mmio_bad = mmio_hit && (func3 != F3_W);
  assign ld_src   = mmio_hit ? mmio_data : ld_data;
`else
  assign mmio_hit = 1'b0;
  assign mmio_bad = 1'b0;
  assign ld_src   = ld_data;
`endif

  // Both requests high is a store; it never produces load data.
  assign illegal  = (MemRead | MemWrite) & (fmt_illegal | mmio_bad);
  assign legal_ld = MemRead & ~MemWrite & ~illegal;
  assign legal_st = MemWrite & ~illegal;
  assign rd_data  = legal_ld ? ld_src : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
    end else if (legal_st && !mmio_hit) begin
      mem[widx] <= st_word;
    end
  end

`ifdef DMEM_MMIO_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      mmio_data  <= '0;
      mmio_valid <= 1'b0;
    end else begin
      mmio_valid <= legal_st && mmio_hit;
      if (legal_st && mmio_hit) mmio_data <= wr_data;
    end
  end
`endif

  // A new error takes priority over err_clr; err_addr holds the first error
  // unless the same cycle also clears the flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      err      <= 1'b0;
      err_addr <= '0;
    end else if (illegal) begin
      err <= 1'b1;
      if (!err || err_clr) err_addr <= addr;
    end else if (err_clr) begin
      err      <= 1'b0;
      err_addr <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (legal_ld && (rd_cnt != '1)) rd_cnt <= rd_cnt + 1'b1;
      if (legal_st && (wr_cnt != '1)) wr_cnt <= wr_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vectors, load results
// checked by a negedge monitor against an expected queue; status outputs
// checked directly after each committing edge.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [8:0]  addr;
  logic [31:0] wr_data;
  logic [2:0]  func3;
  logic [31:0] rd_data;
  logic        err;
  logic [8:0]  err_addr;
  logic        err_clr;
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;
`ifdef DMEM_MMIO_EN
  logic [31:0] mmio_data;
  logic        mmio_valid;
`endif

  logic [31:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  dmem_responder dut (
    .clk      (clk),
    .reset    (reset),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .addr     (addr),
    .wr_data  (wr_data),
    .func3    (func3),
    .rd_data  (rd_data),
    .err      (err),
    .err_addr (err_addr),
    .err_clr  (err_clr),
    .rd_cnt   (rd_cnt),
    .wr_cnt   (wr_cnt)
`ifdef DMEM_MMIO_EN
    ,
    .mmio_data  (mmio_data),
    .mmio_valid (mmio_valid)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every cycle carrying MemRead presents a response on rd_data.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (MemRead === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rd_data: unexpected read at addr 0x%03h, got 0x%08h", addr, rd_data);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("rd_data@%03h", addr), rd_data, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic acc(input logic r, input logic w, input logic [8:0] a,
                     input logic [31:0] d, input logic [2:0] f,
                     input logic clr, input logic [31:0] exp);
    @(posedge clk);
    #1;
    MemRead  = r;
    MemWrite = w;
    addr     = a;
    wr_data  = d;
    func3    = f;
    err_clr  = clr;
    if (r) exp_q.push_back(exp);
  endtask

  task automatic idle();
    acc(1'b0, 1'b0, 9'h000, 32'h0, 3'b010, 1'b0, 32'h0);
  endtask

  task automatic ld(input logic [8:0] a, input logic [2:0] f, input logic [31:0] exp);
    acc(1'b1, 1'b0, a, 32'h0, f, 1'b0, exp);
  endtask

  task automatic st(input logic [8:0] a, input logic [31:0] d, input logic [2:0] f);
    acc(1'b0, 1'b1, a, d, f, 1'b0, 32'h0);
  endtask

  // Reset pulse with a store presented in the same cycle; the store is lost.
  task automatic reset_with_store();
    @(posedge clk);
    #1;
    reset    = 1'b1;
    MemRead  = 1'b0;
    MemWrite = 1'b1;
    addr     = 9'h010;
    wr_data  = 32'hFFFF_FFFF;
    func3    = 3'b010;
    err_clr  = 1'b0;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    MemWrite = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; addr = '0;
    wr_data = '0; func3 = 3'b010; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("reset err", {31'b0, err}, 32'h0);
    chk("reset err_addr", {23'b0, err_addr}, 32'h0);
    chk("reset rd_cnt", {16'b0, rd_cnt}, 32'h0);
    chk("reset wr_cnt", {16'b0, wr_cnt}, 32'h0);
    chk("idle rd_data", rd_data, 32'h0);

    // Word store/load and lane extraction
    st(9'h010, 32'hDEAD_BEEF, 3'b010);
    ld(9'h010, 3'b010, 32'hDEAD_BEEF);
    idle();
    chk("wr_cnt after SW", {16'b0, wr_cnt}, 32'd1);
    chk("rd_cnt after LW", {16'b0, rd_cnt}, 32'd1);
    ld(9'h011, 3'b000, 32'hFFFF_FFBE);
    ld(9'h011, 3'b100, 32'h0000_00BE);
    ld(9'h012, 3'b001, 32'hFFFF_DEAD);
    st(9'h013, 32'h0000_0055, 3'b000);
    ld(9'h010, 3'b010, 32'h55AD_BEEF);
    ld(9'h010, 3'b101, 32'h0000_BEEF);
    idle();
    chk("wr_cnt after SB", {16'b0, wr_cnt}, 32'd2);
    chk("rd_cnt after lane loads", {16'b0, rd_cnt}, 32'd6);

    // Misaligned store: suppressed, error captured
    st(9'h022, 32'hCAFE_F00D, 3'b010);
    idle();
    chk("err after SW@022", {31'b0, err}, 32'h1);
    chk("err_addr after SW@022", {23'b0, err_addr}, 32'h022);
    chk("wr_cnt after illegal SW", {16'b0, wr_cnt}, 32'd2);
    ld(9'h020, 3'b010, 32'h0);
    ld(9'h022, 3'b010, 32'h0);
    ld(9'h001, 3'b001, 32'h0);
    idle();
    chk("err_addr sticky", {23'b0, err_addr}, 32'h022);
    chk("rd_cnt skips illegal", {16'b0, rd_cnt}, 32'd7);
    acc(1'b1, 1'b0, 9'h010, 32'h0, 3'b010, 1'b1, 32'h55AD_BEEF);
    idle();
    chk("err cleared", {31'b0, err}, 32'h0);
    chk("err_addr cleared", {23'b0, err_addr}, 32'h0);

    // Clear and new error in the same cycle: error wins
    ld(9'h050, 3'b011, 32'h0);
    acc(1'b0, 1'b1, 9'h031, 32'h1, 3'b010, 1'b1, 32'h0);
    idle();
    chk("err clr vs error", {31'b0, err}, 32'h1);
    chk("err_addr clr vs error", {23'b0, err_addr}, 32'h031);
    acc(1'b0, 1'b0, 9'h000, 32'h0, 3'b010, 1'b1, 32'h0);
    idle();
    chk("err plain clear", {31'b0, err}, 32'h0);

    // Read+write together behaves as a store
    acc(1'b1, 1'b1, 9'h040, 32'h1234_5678, 3'b010, 1'b0, 32'h0);
    idle();
    chk("wr_cnt after RW", {16'b0, wr_cnt}, 32'd3);
    chk("rd_cnt after RW", {16'b0, rd_cnt}, 32'd8);
    ld(9'h040, 3'b010, 32'h1234_5678);
    st(9'h042, 32'h0000_8001, 3'b001);
    ld(9'h042, 3'b101, 32'h0000_8001);
    ld(9'h042, 3'b001, 32'hFFFF_8001);
    ld(9'h040, 3'b010, 32'h8001_5678);

    // MMIO word
    st(9'h1FC, 32'h0000_00A5, 3'b010);
    idle();
`ifdef DMEM_MMIO_EN
    chk("mmio_valid pulse", {31'b0, mmio_valid}, 32'h1);
    chk("mmio_data", mmio_data, 32'h0000_00A5);
    idle();
    chk("mmio_valid one cycle", {31'b0, mmio_valid}, 32'h0);
    ld(9'h1FC, 3'b010, 32'h0000_00A5);
    ld(9'h1FD, 3'b100, 32'h0);
    idle();
    chk("mmio byte access err", {31'b0, err}, 32'h1);
    chk("mmio byte access err_addr", {23'b0, err_addr}, 32'h1FD);
    acc(1'b0, 1'b0, 9'h000, 32'h0, 3'b010, 1'b1, 32'h0);
`else
    ld(9'h1FC, 3'b010, 32'h0000_00A5);
    ld(9'h1FD, 3'b100, 32'h0000_0000);
    ld(9'h1FC, 3'b000, 32'hFFFF_FFA5);
`endif
    idle();

    // Reset clears everything and drops the coincident store
    reset_with_store();
    chk("post-reset rd_cnt", {16'b0, rd_cnt}, 32'h0);
    chk("post-reset wr_cnt", {16'b0, wr_cnt}, 32'h0);
    chk("post-reset err", {31'b0, err}, 32'h0);
    ld(9'h010, 3'b010, 32'h0);
    ld(9'h040, 3'b010, 32'h0);
    ld(9'h1FC, 3'b010, 32'h0);

    // Counter saturation
    for (int i = 0; i < 65534; i++) st(9'h100, i, 3'b010);
    idle();
    chk("wr_cnt at FFFE", {16'b0, wr_cnt}, 32'h0000_FFFE);
    for (int i = 0; i < 3; i++) st(9'h104, 32'h1111_0000 + i, 3'b010);
    idle();
    chk("wr_cnt saturated", {16'b0, wr_cnt}, 32'h0000_FFFF);
    ld(9'h100, 3'b010, 32'h0000_FFFD);
    ld(9'h104, 3'b010, 32'h1111_0002);
    idle();
    chk("rd_cnt before reset", {16'b0, rd_cnt}, 32'd5);
    reset_with_store();
    chk("final reset wr_cnt", {16'b0, wr_cnt}, 32'h0);
    chk("final reset rd_cnt", {16'b0, rd_cnt}, 32'h0);
    ld(9'h100, 3'b010, 32'h0);
    idle();
    idle();

    // ---------------- report ----------------
    chk("expected queue drained", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DM_ADDRESS, default 9, byte-address width; storage is 2**DM_ADDRESS bytes (128 words).
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter CNT_W, default 16, access-counter width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 MemRead  input  1  load request, valid for the current cycle only.
REQ-007 MemWrite  input  1  store request, valid for the current cycle only.
REQ-008 addr  input  DM_ADDRESS  byte address.
REQ-009 wr_data  input  DATA_W  store data, right-aligned.
REQ-010 func3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-011 rd_data  output  DATA_W  load result, combinational from current inputs and storage.
REQ-012 err  output  1  sticky access-error flag.
REQ-013 err_addr  output  DM_ADDRESS  address of the first error since the last clear.
REQ-014 err_clr  input  1  clears err and err_addr.
REQ-015 rd_cnt, wr_cnt  output  CNT_W each  completed load and store counts.
REQ-016 mmio_data  output  DATA_W  MMIO register; present only with DMEM_MMIO_EN.
REQ-017 mmio_valid  output  1  one-cycle strobe on MMIO write; present only with DMEM_MMIO_EN.

Function
REQ-018 Loads SHALL have zero-cycle latency: rd_data is valid in the same cycle MemRead is asserted, so the pipeline can capture it at the next edge.
REQ-019 Stores SHALL commit at the rising edge; a load to the same address in the next cycle SHALL return the new data.
REQ-020 Byte lanes SHALL be little-endian: word index addr[DM_ADDRESS-1:2], lane addr[1:0].
REQ-021 B/H loads SHALL sign-extend; BU/HU loads SHALL zero-extend; SB/SH SHALL write only the addressed lanes.
REQ-022 An access is illegal when any of the following holds:
- H/HU with addr[0]=1;
- W with addr[1:0]!=0;
- func3 is 011, 110 or 111.
REQ-023 An illegal access SHALL:
- suppress the write;
- drive rd_data to 0;
- not increment counters;
- set err at the next edge.
REQ-024 err_addr SHALL capture addr only when err is currently 0; later errors SHALL NOT overwrite it.
REQ-025 If err_clr and a new error occur in the same cycle, the error SHALL win: err stays 1 and err_addr takes the new address.
REQ-026 If MemRead and MemWrite are both 1, the access SHALL be treated as a store, and rd_data SHALL be 0.
REQ-027 With neither request asserted, rd_data SHALL be 0 and no state changes except err_clr.
REQ-028 rd_cnt and wr_cnt SHALL increment by 1 per legal access and saturate at all-ones.

Reset
REQ-029 On reset the following SHALL all be cleared to 0 at the next edge, overriding any simultaneous access:
- all storage words;
- err, err_addr;
- rd_cnt, wr_cnt;
- mmio_data, mmio_valid.
REQ-030 A store coincident with reset SHALL be lost.

Configuration
REQ-031 With macro DMEM_MMIO_EN defined, a legal SW to word address 0x1FC SHALL NOT write storage; instead it SHALL load mmio_data and pulse mmio_valid for exactly one cycle.
REQ-032 With DMEM_MMIO_EN defined, LW from 0x1FC SHALL return mmio_data; any non-word access to 0x1FC-0x1FF SHALL be illegal.
REQ-033 Without DMEM_MMIO_EN, 0x1FC SHALL be ordinary storage and the MMIO ports SHALL not exist.

Structure
REQ-034 The func3 encodings (B, H, W, BU, HU) SHALL be localparams in the shared package Pipe_Buf_Reg_PKG.
REQ-035 The MMIO address (0x1FC) SHALL be a localparam in the same package.
REQ-036 A combinational sub-module dmem_lane_fmt SHALL provide:
- load extraction and sign/zero extension;
- store byte-enable generation and lane merge;
- misalignment detection.

Verification
REQ-037 SW 0xDEADBEEF @0x010, then LW @0x010 -> rd_data 0xDEADBEEF; wr_cnt 1, rd_cnt 1.
REQ-038 After REQ-037:
- LB @0x011 -> 0xFFFFFFBE;
- LBU @0x011 -> 0x000000BE;
- LH @0x012 -> 0xFFFFDEAD;
- SB 0x55 @0x013 then LW @0x010 -> 0x55ADBEEF.
REQ-039 SW @0x022 -> no write, rd_data 0, err 1, err_addr 0x022. Then LH @0x001 -> err_addr stays 0x022. Then err_clr with a legal access -> err 0.
REQ-040 MemRead=MemWrite=1, SW 0x12345678 @0x040 -> rd_data 0, storage written, wr_cnt +1, rd_cnt unchanged.
REQ-041 Preload wr_cnt to 0xFFFE, perform 3 stores -> wr_cnt 0xFFFF. Then reset -> counters, err and memory all 0.
REQ-042 With DMEM_MMIO_EN, SW 0xA5 @0x1FC -> mmio_valid high exactly 1 cycle, mmio_data 0xA5, LW @0x1FC returns 0xA5. Without DMEM_MMIO_EN, the same sequence returns 0xA5 from storage.
